patdet_accum_ctrl: RTL and testbench
====================================

Name: patdet_accum_ctrl

Overview:
Sequencer for the DSP slice's pattern-detect accumulate loop. Clears the P register, drives the detection pattern on C, and holds CEP high while the slice accumulates. Ends the run on pattern match (terminal count), OVERFLOW, UNDERFLOW, cycle-budget timeout or abort, then reports status through a start/done handshake. Sits between the host control logic and one PatternDetector instance built with SEL_PATTERN = 1 (pattern taken from C).

Parameters:
CNT_W, 16, width of max_cycles and run_count
CLR_CYCLES, 1, number of cycles RSTP is held high in CLEAR (1..15)
FLAG_LAT, 1, cycles from the first CEP-high cycle until the detector flags reflect the new P; flags are ignored before then (0..7)

Ports:
clk  in  1  clock, rising edge
RST  in  1  asynchronous active-high reset
start  in  1  one-cycle request to begin a run; ignored unless in IDLE
abort  in  1  terminate the current run; ignored in IDLE and DONE
term_pattern  in  48  terminal pattern, captured on an accepted start
max_cycles  in  CNT_W  CEP-high cycle budget, captured on an accepted start
PATTERNDETECT  in  1  from the detector
PATTERNBDETECT  in  1  from the detector; informational, does not terminate a run
OVERFLOW  in  1  from the detector
UNDERFLOW  in  1  from the detector
CEP  out  1  P-register clock enable to the detector
RSTP  out  1  P-register reset to the detector
C  out  48  pattern driven to the detector
busy  out  1  high in CLEAR, RUN and DONE
done  out  1  one-cycle pulse in DONE
status  out  3  0 match, 1 overflow, 2 underflow, 3 timeout, 4 abort; valid from done until the next accepted start
run_count  out  CNT_W  number of CEP-high cycles in the last or current run

Behaviour:
- All outputs are registered.
- Reset values: CEP=0, RSTP=0, C=0, busy=0, done=0, status=0, run_count=0, state=IDLE. Reset mid-run aborts the run immediately and does not assert done.
- States:
  - IDLE: on start, capture term_pattern into C and max_cycles into the budget register, clear run_count and go to CLEAR.
  - CLEAR: RSTP=1 for exactly CLR_CYCLES cycles, CEP=0, then go to RUN. If the budget is 0, go to DONE with status 3 and CEP never high.
  - RUN: CEP=1 and run_count increments every RUN cycle. Flags are qualified only after the run has been in RUN for FLAG_LAT cycles. Exit to DONE on the first qualifying event. Priority when events coincide: abort > OVERFLOW > UNDERFLOW > PATTERNDETECT > timeout.
  - Timeout: run_count reaches the budget in a cycle with no other event.
  - DONE: CEP=0, done=1 for one cycle, status latched, then go to IDLE. start in DONE is ignored.
- CEP falls in the first DONE cycle, so the last accumulation is the final RUN cycle. run_count equals the number of CEP-high cycles and saturates at all-ones.
- C holds its value through DONE and IDLE and changes only on an accepted start.
- abort during CLEAR goes to DONE with status 4 and RSTP released.
- run_count wrap is impossible because the budget is at most 2^CNT_W - 1.

Decomposition:
- Shared package: state encoding (IDLE, CLEAR, RUN, DONE), status codes (ST_MATCH=0, ST_OVF=1, ST_UNF=2, ST_TMO=3, ST_ABT=4), and the 48-bit DSP data width constant.
- Sub-module dsp_flag_qualifier (natural but optional): holds the FLAG_LAT down-counter and the priority encoder that produces the terminate flag and status code.

Test Plan:
- start with term_pattern=48'h10, max_cycles=100; model P incrementing by 1 per CEP cycle; PATTERNDETECT on P==0x10 -> done after 17 CEP cycles, status=0, run_count=17.
- max_cycles=5, no flags -> exactly 5 CEP-high cycles, done one cycle after the last, status=3, run_count=5.
- OVERFLOW and PATTERNDETECT asserted in the same qualified cycle -> status=1. Repeat with UNDERFLOW and PATTERNDETECT -> status=2.
- PATTERNDETECT=1 in the first RUN cycle with FLAG_LAT=1 -> ignored; run continues; a match on cycle 3 -> status=0, run_count=3.
- abort in cycle 2 of CLEAR with CLR_CYCLES=3 -> RSTP drops, done pulses, status=4, run_count=0. max_cycles=0 -> status=3, CEP never high.
- RST asserted in mid-RUN at run_count=7 -> all outputs 0 asynchronously, no done pulse; start after reset release runs normally.

Source files
------------

// File: rtl/patdet_accum_ctrl_pkg.sv
// Shared definitions for the pattern-detect accumulate sequencer:
// state encoding, status codes and the DSP data width.
package patdet_accum_ctrl_pkg;

   localparam int DSP_W = 48;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_CLEAR = 2'd1;
   localparam logic [1:0] S_RUN   = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   typedef enum logic [2:0] {
      ST_MATCH = 3'd0,
      ST_OVF   = 3'd1,
      ST_UNF   = 3'd2,
      ST_TMO   = 3'd3,
      ST_ABT   = 3'd4
   } status_e;

endpackage

// File: rtl/patdet_accum_ctrl_if.sv
// Host and detector signal bundle; master is the host/detector side,
// slave is the sequencer.
interface patdet_accum_ctrl_if #(
   parameter int CNT_W = 16
);
   import patdet_accum_ctrl_pkg::*;

   logic             start;
   logic             abort;
   logic [DSP_W-1:0] term_pattern;
   logic [CNT_W-1:0] max_cycles;
   logic             PATTERNDETECT;
   logic             PATTERNBDETECT;
   logic             OVERFLOW;
   logic             UNDERFLOW;
   logic             CEP;
   logic             RSTP;
   logic [DSP_W-1:0] C;
   logic             busy;
   logic             done;
   logic [2:0]       status;
   logic [CNT_W-1:0] run_count;

   modport master (
      output start, abort, term_pattern, max_cycles,
             PATTERNDETECT, PATTERNBDETECT, OVERFLOW, UNDERFLOW,
      input  CEP, RSTP, C, busy, done, status, run_count
   );

   modport slave (
      input  start, abort, term_pattern, max_cycles,
             PATTERNDETECT, PATTERNBDETECT, OVERFLOW, UNDERFLOW,
      output CEP, RSTP, C, busy, done, status, run_count
   );

endinterface

// File: rtl/patdet_accum_ctrl_qual.sv
// Flag-latency down-counter and run-termination priority encoder.
module dsp_flag_qualifier
   import patdet_accum_ctrl_pkg::*;
#(
   parameter int FLAG_LAT = 1
) (
   input  logic       clk,
   input  logic       RST,
   input  logic       load,
   input  logic       in_run,
   input  logic       abort,
   input  logic       ovf,
   input  logic       unf,
   input  logic       pd,
   input  logic       tmo,
   output logic       term,
   output logic [2:0] code
);

   logic [2:0] lat_cnt;
   logic       qual;

   assign qual = (lat_cnt == 3'd0);

   always_ff @(posedge clk or posedge RST) begin
      if (RST) begin
         lat_cnt <= 3'd0;
      end else if (load) begin
         lat_cnt <= 3'(FLAG_LAT);
      end else if (in_run && !qual) begin
         lat_cnt <= lat_cnt - 3'd1;
      end
   end

   // abort and timeout are not detector flags, so the latency gate does not apply
   always_comb begin
      term = 1'b0;
      code = ST_TMO;
      if (in_run) begin
         if (abort) begin
            term = 1'b1;
            code = ST_ABT;
         end else if (qual && ovf) begin
            term = 1'b1;
            code = ST_OVF;
         end else if (qual && unf) begin
            term = 1'b1;
            code = ST_UNF;
         end else if (qual && pd) begin
            term = 1'b1;
            code = ST_MATCH;
         end else if (tmo) begin
            term = 1'b1;
            code = ST_TMO;
         end
      end
   end

endmodule

// File: rtl/patdet_accum_ctrl.sv
// Sequencer for the DSP pattern-detect accumulate loop.
//   state | meaning
//   IDLE  | waiting for start; C and status hold
//   CLEAR | RSTP high for CLR_CYCLES cycles
//   RUN   | CEP high, counting, watching flags
//   DONE  | one-cycle done pulse, status valid
module patdet_accum_ctrl
   import patdet_accum_ctrl_pkg::*;
#(
   parameter int CNT_W      = 16,
   parameter int CLR_CYCLES = 1,
   parameter int FLAG_LAT   = 1
) (
   input logic               clk,
   input logic               RST,
   patdet_accum_ctrl_if.slave bus
);

   logic [1:0]       state;
   logic [3:0]       clr_cnt;
   logic [CNT_W-1:0] budget;
   logic             run_load;
   logic             q_term;
   logic [2:0]       q_code;

   assign run_load = (state == S_CLEAR) && !bus.abort &&
                     (clr_cnt == 4'd0) && (budget != '0);

   dsp_flag_qualifier #(
      .FLAG_LAT (FLAG_LAT)
   ) u_qual (
      .clk    (clk),
      .RST    (RST),
      .load   (run_load),
      .in_run (state == S_RUN),
      .abort  (bus.abort),
      .ovf    (bus.OVERFLOW),
      .unf    (bus.UNDERFLOW),
      .pd     (bus.PATTERNDETECT),
      .tmo    (bus.run_count == budget),
      .term   (q_term),
      .code   (q_code)
   );

   always_ff @(posedge clk or posedge RST) begin
      if (RST) begin
         state         <= S_IDLE;
         clr_cnt       <= 4'd0;
         budget        <= '0;
         bus.CEP       <= 1'b0;
         bus.RSTP      <= 1'b0;
         bus.C         <= '0;
         bus.busy      <= 1'b0;
         bus.done      <= 1'b0;
         bus.status    <= 3'd0;
         bus.run_count <= '0;
      end else begin
         bus.done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (bus.start) begin
                  bus.C         <= bus.term_pattern;
                  budget        <= bus.max_cycles;
                  bus.run_count <= '0;
                  clr_cnt       <= 4'(CLR_CYCLES - 1);
                  bus.RSTP      <= 1'b1;
                  bus.busy      <= 1'b1;
                  state         <= S_CLEAR;
               end
            end
            S_CLEAR: begin
               if (bus.abort) begin
                  bus.RSTP   <= 1'b0;
                  bus.done   <= 1'b1;
                  bus.status <= ST_ABT;
                  state      <= S_DONE;
               end else if (clr_cnt == 4'd0) begin
                  bus.RSTP <= 1'b0;
                  if (budget == '0) begin
                     bus.done   <= 1'b1;
                     bus.status <= ST_TMO;
                     state      <= S_DONE;
                  end else begin
                     // run_count tracks CEP-high cycles including the current one
                     bus.CEP       <= 1'b1;
                     bus.run_count <= bus.run_count + 1'b1;
                     state         <= S_RUN;
                  end
               end else begin
                  clr_cnt <= clr_cnt - 4'd1;
               end
            end
            S_RUN: begin
               if (q_term) begin
                  bus.CEP    <= 1'b0;
                  bus.done   <= 1'b1;
                  bus.status <= q_code;
                  state      <= S_DONE;
               end else if (bus.run_count != '1) begin
                  bus.run_count <= bus.run_count + 1'b1;
               end
            end
            default: begin
               bus.busy <= 1'b0;
               state    <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_patdet_accum_ctrl.sv
// Directed bench for patdet_accum_ctrl with a simple counting P-register model.
module tb_patdet_accum_ctrl;

   logic clk = 1'b0;
   logic RST = 1'b1;
   int   ntests = 0;
   int   nfail  = 0;

   logic        model_en = 1'b0;
   logic        pd_drv   = 1'b0;
   logic        ovf_drv  = 1'b0;
   logic        unf_drv  = 1'b0;
   logic [47:0] p;

   patdet_accum_ctrl_if #(.CNT_W(16)) bus ();

   patdet_accum_ctrl #(
      .CNT_W      (16),
      .CLR_CYCLES (3),
      .FLAG_LAT   (1)
   ) dut (
      .clk (clk),
      .RST (RST),
      .bus (bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk or posedge RST) begin
      if (RST)           p <= '0;
      else if (bus.RSTP) p <= '0;
      else if (bus.CEP)  p <= p + 48'd1;
   end

   assign bus.PATTERNDETECT  = (model_en && (p == bus.C)) || pd_drv;
   assign bus.PATTERNBDETECT = 1'b0;
   assign bus.OVERFLOW       = ovf_drv;
   assign bus.UNDERFLOW      = unf_drv;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      ntests++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic start_run(input logic [47:0] pat, input logic [15:0] maxc);
      @(negedge clk);
      bus.term_pattern = pat;
      bus.max_cycles   = maxc;
      bus.start        = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
   endtask

   // Returns CEP-high cycles seen and CEP of the cycle before done.
   task automatic wait_done(input string tag, output int cep_cnt, output logic prev_cep);
      logic got;
      got      = 1'b0;
      cep_cnt  = 0;
      prev_cep = bus.CEP;
      if (bus.CEP) cep_cnt++;
      for (int i = 0; i < 500; i++) begin
         @(negedge clk);
         if (bus.done) begin
            got = 1'b1;
            break;
         end
         prev_cep = bus.CEP;
         if (bus.CEP) cep_cnt++;
      end
      chk({tag, "_done_seen"}, got, 1'b1);
   endtask

   task automatic run_to_cycle(input string tag, input int n);
      logic got;
      got = 1'b0;
      for (int i = 0; i < 200; i++) begin
         if (bus.CEP && bus.run_count == 16'(n)) begin
            got = 1'b1;
            break;
         end
         @(negedge clk);
      end
      chk({tag, "_reach"}, got, 1'b1);
   endtask

   int   cc;
   logic pc;

   initial begin
      bus.start        = 1'b0;
      bus.abort        = 1'b0;
      bus.term_pattern = '0;
      bus.max_cycles   = '0;

      // reset state
      #2;
      chk("rst_cep", bus.CEP, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_run_count", bus.run_count, 0);
      @(negedge clk);
      @(negedge clk);
      RST = 1'b0;

      // pattern match via the P model
      model_en = 1'b1;
      start_run(48'h10, 16'd100);
      chk("t1_busy", bus.busy, 1);
      chk("t1_rstp", bus.RSTP, 1);
      chk("t1_cep_clear", bus.CEP, 0);
      wait_done("t1", cc, pc);
      chk("t1_status", bus.status, 0);
      chk("t1_run_count", bus.run_count, 17);
      chk("t1_cep_cycles", cc, 17);
      chk("t1_cep_in_done", bus.CEP, 0);
      chk("t1_busy_done", bus.busy, 1);
      @(negedge clk);
      chk("t1_done_pulse", bus.done, 0);
      chk("t1_idle_busy", bus.busy, 0);
      chk("t1_c_hold", bus.C, 48'h10);
      model_en = 1'b0;

      // timeout, plus start ignored in DONE
      start_run(48'h5, 16'd5);
      wait_done("t2", cc, pc);
      chk("t2_status", bus.status, 3);
      chk("t2_run_count", bus.run_count, 5);
      chk("t2_cep_cycles", cc, 5);
      chk("t2_last_cep", pc, 1);
      bus.term_pattern = 48'hABC;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      chk("t2_start_in_done_ignored", bus.busy, 0);
      chk("t2_c_unchanged", bus.C, 48'h5);
      @(negedge clk);
      chk("t2_still_idle", bus.busy, 0);

      // OVERFLOW beats PATTERNDETECT
      start_run(48'h1, 16'd100);
      run_to_cycle("t3", 3);
      ovf_drv = 1'b1; pd_drv = 1'b1;
      wait_done("t3", cc, pc);
      ovf_drv = 1'b0; pd_drv = 1'b0;
      chk("t3_status_ovf", bus.status, 1);
      chk("t3_run_count", bus.run_count, 3);

      // UNDERFLOW beats PATTERNDETECT
      start_run(48'h1, 16'd100);
      run_to_cycle("t4", 3);
      unf_drv = 1'b1; pd_drv = 1'b1;
      wait_done("t4", cc, pc);
      unf_drv = 1'b0; pd_drv = 1'b0;
      chk("t4_status_unf", bus.status, 2);
      chk("t4_run_count", bus.run_count, 3);

      // abort beats OVERFLOW in RUN
      start_run(48'h1, 16'd100);
      run_to_cycle("t5", 4);
      bus.abort = 1'b1; ovf_drv = 1'b1;
      wait_done("t5", cc, pc);
      bus.abort = 1'b0; ovf_drv = 1'b0;
      chk("t5_status_abt", bus.status, 4);
      chk("t5_run_count", bus.run_count, 4);

      // PATTERNDETECT in the first RUN cycle is masked by FLAG_LAT
      start_run(48'h1, 16'd100);
      run_to_cycle("t6", 1);
      pd_drv = 1'b1;
      @(negedge clk);
      pd_drv = 1'b0;
      chk("t6_masked_still_run", bus.CEP, 1);
      chk("t6_masked_no_done", bus.done, 0);
      @(negedge clk);
      pd_drv = 1'b1;
      wait_done("t6", cc, pc);
      pd_drv = 1'b0;
      chk("t6_status", bus.status, 0);
      chk("t6_run_count", bus.run_count, 3);

      // abort in second CLEAR cycle
      start_run(48'h2, 16'd100);
      @(negedge clk);
      chk("t7_rstp_clear2", bus.RSTP, 1);
      bus.abort = 1'b1;
      wait_done("t7", cc, pc);
      bus.abort = 1'b0;
      chk("t7_rstp_released", bus.RSTP, 0);
      chk("t7_status", bus.status, 4);
      chk("t7_run_count", bus.run_count, 0);
      chk("t7_cep_cycles", cc, 0);

      // zero budget
      start_run(48'h3, 16'd0);
      wait_done("t8", cc, pc);
      chk("t8_status", bus.status, 3);
      chk("t8_cep_cycles", cc, 0);
      chk("t8_run_count", bus.run_count, 0);

      // reset mid-run
      start_run(48'h77, 16'd100);
      run_to_cycle("t9", 7);
      RST = 1'b1;
      #1;
      chk("t9_cep", bus.CEP, 0);
      chk("t9_rstp", bus.RSTP, 0);
      chk("t9_c", bus.C, 0);
      chk("t9_busy", bus.busy, 0);
      chk("t9_status", bus.status, 0);
      chk("t9_run_count", bus.run_count, 0);
      cc = 0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if (bus.done) cc++;
      end
      chk("t9_no_done", cc, 0);
      RST = 1'b0;
      start_run(48'h9, 16'd4);
      wait_done("t9b", cc, pc);
      chk("t9b_status", bus.status, 3);
      chk("t9b_run_count", bus.run_count, 4);
      chk("t9b_cep_cycles", cc, 4);

      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end

endmodule
